trng_health: RTL and testbench

TRNG_HEALTH -- requirements
Module: trng_health

---
 rtl/trng_pkg.sv | 23 ++
 rtl/trng_health_test.sv | 92 +++++++++
 rtl/trng_health.sv | 210 +++++++++++++++++++++
 tb/tb_trng_health.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG front end and its health tests.
package trng_pkg;

    // Main conditioning FSM states.
    typedef enum logic [1:0] {
        StStartup = 2'd0,
        StFill    = 2'd1,
        StHold    = 2'd2,
        StAlarm   = 2'd3
    } state_e;

    // alarm_cause encodings.
    localparam logic [1:0] CauseNone = 2'b00;
    localparam logic [1:0] CauseRct  = 2'b01;
    localparam logic [1:0] CauseApt  = 2'b10;
    localparam logic [1:0] CauseBoth = 2'b11;

    // Default health-test limits.
    localparam int unsigned DefRctCutoff = 32;
    localparam int unsigned DefAptWindow = 1024;
    localparam int unsigned DefAptCutoff = 589;

endpackage

// File: rtl/trng_health_test.sv
// Repetition-count and adaptive-proportion tests on the raw bit stream.
// fail/cause are combinational for the bit presented this cycle, so the
// caller can act on the same clock edge that consumes the bit.
module trng_health_test
    import trng_pkg::*;
#(
    parameter int unsigned RCT_CUTOFF = DefRctCutoff,
    parameter int unsigned APT_WINDOW = DefAptWindow,
    parameter int unsigned APT_CUTOFF = DefAptCutoff
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_bit,
    input  logic       en,
    output logic       fail,
    output logic [1:0] cause
);

    localparam int unsigned RunW   = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned WinW   = $clog2(APT_WINDOW + 1);
    localparam int unsigned MatchW = $clog2(APT_CUTOFF + 1);

    logic [RunW-1:0]   run_q, run_d;
    logic              last_q, last_d;
    logic [WinW-1:0]   win_q, win_d;
    logic [MatchW-1:0] match_q, match_d;
    logic              ref_q, ref_d;
    logic              rct_fail, apt_fail;

    // Next-state for both tests; run_q == 0 means no previous bit seen yet.
    always_comb begin
        run_d    = run_q;
        last_d   = last_q;
        win_d    = win_q;
        match_d  = match_q;
        ref_d    = ref_q;
        rct_fail = 1'b0;
        apt_fail = 1'b0;
        if (en) begin
            last_d = raw_bit;
            if (run_q != '0 && raw_bit == last_q) begin
                run_d = run_q + RunW'(1);
            end else begin
                run_d = RunW'(1);
            end

            // First bit of a window becomes the reference and counts as a match.
            if (win_q == '0) begin
                ref_d   = raw_bit;
                match_d = MatchW'(1);
            end else if (raw_bit == ref_q) begin
                match_d = match_q + MatchW'(1);
            end
            win_d = (win_q == WinW'(APT_WINDOW - 1)) ? '0 : win_q + WinW'(1);

            rct_fail = (run_d == RunW'(RCT_CUTOFF));
            apt_fail = (match_d == MatchW'(APT_CUTOFF));
        end
    end

    // Encode which test(s) tripped.
    always_comb begin
        cause = CauseNone;
        if (rct_fail && apt_fail) begin
            cause = CauseBoth;
        end else if (rct_fail) begin
            cause = CauseRct;
        end else if (apt_fail) begin
            cause = CauseApt;
        end
    end

    assign fail = rct_fail | apt_fail;

    // Counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= '0;
            last_q  <= 1'b0;
            win_q   <= '0;
            match_q <= '0;
            ref_q   <= 1'b0;
        end else begin
            run_q   <= run_d;
            last_q  <= last_d;
            win_q   <= win_d;
            match_q <= match_d;
            ref_q   <= ref_d;
        end
    end

endmodule

// File: rtl/trng_health.sv
// Ring-oscillator TRNG front end: samples and XOR-reduces the oscillators,
// assembles words, discards the start-up words and gates delivery on the
// health tests. A health failure latches a sticky alarm until reset.
// STARTUP_WORDS must be at least 1.
module trng_health
    import trng_pkg::*;
#(
    parameter int unsigned N_RO          = 32,
    parameter int unsigned OUT_W         = 64,
    parameter int unsigned STARTUP_WORDS = 4,
    parameter int unsigned RCT_CUTOFF    = DefRctCutoff,
    parameter int unsigned APT_WINDOW    = DefAptWindow,
    parameter int unsigned APT_CUTOFF    = DefAptCutoff
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             test_mode,
    input  logic             test_bit,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             alarm,
    output logic [1:0]       alarm_cause
);

    localparam int unsigned CntW = $clog2(OUT_W + 1);
    localparam int unsigned WcW  = $clog2(STARTUP_WORDS + 1);

    logic [N_RO-1:0]  taps;
    logic [N_RO-1:0]  sample_in, sample_q;
    logic             primed_q;
    logic             raw_bit, bit_vld, accept, word_done;
    logic             hc_en, hc_fail;
    logic [1:0]       hc_cause;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WcW-1:0]   word_cnt_q, word_cnt_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             alarm_q, alarm_d;
    logic [1:0]       cause_q, cause_d;

`ifdef SIMULATION
    // Behavioural stand-in for the oscillators: an xorshift generator.
    logic [31:0] lfsr_q, lfsr_d;

    // Advance the generator one step per clock.
    always_comb begin
        lfsr_d = lfsr_q;
        lfsr_d = lfsr_d ^ (lfsr_d << 13);
        lfsr_d = lfsr_d ^ (lfsr_d >> 17);
        lfsr_d = lfsr_d ^ (lfsr_d << 5);
    end

    // Generator state register, seeded non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 32'h1D87_2B41;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    for (genvar g = 0; g < N_RO; g++) begin : g_ro
        assign taps[g] = lfsr_q[g % 32] ^ lfsr_q[(g * 13 + 5) % 32];
    end
`else
    // Oscillators only run while they are actually being sampled; the gated
    // first stage parks each loop in a stable state otherwise.
    logic ro_run;
    assign ro_run = en & ~test_mode & ~rst;

    for (genvar g = 0; g < N_RO; g++) begin : g_ro
        logic n0, n1, n2;
        assign n0      = ~(n2 & ro_run);
        assign n1      = ~n0;
        assign n2      = ~n1;
        assign taps[g] = n2;
    end
`endif

    // Select oscillator taps or the injected test bit.
    always_comb begin
        sample_in = taps;
        if (test_mode) begin
            sample_in    = '0;
            sample_in[0] = test_bit;
        end
    end

    // Sample register; primed_q marks that sample_q holds a real sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            primed_q <= 1'b0;
        end else if (en) begin
            sample_q <= sample_in;
            primed_q <= 1'b1;
        end
    end

    // The held sample is consumed on the edge that takes the next one, so a
    // gap in en loses no bits.
    assign raw_bit   = ^sample_q;
    assign bit_vld   = en & primed_q;
    assign hc_en     = bit_vld & (state_q != StAlarm);
    assign accept    = bit_vld & ((state_q == StStartup) | (state_q == StFill));
    assign word_done = accept & (bit_cnt_q == CntW'(OUT_W - 1));

    trng_health_test #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health_test (
        .clk     (clk),
        .rst     (rst),
        .raw_bit (raw_bit),
        .en      (hc_en),
        .fail    (hc_fail),
        .cause   (hc_cause)
    );

    // Word assembly, delivery handshake and alarm next-state.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        alarm_d     = alarm_q;
        cause_d     = cause_q;

        if (accept) begin
            shift_d   = {shift_q[OUT_W-2:0], raw_bit};
            bit_cnt_d = word_done ? '0 : bit_cnt_q + CntW'(1);
        end

        case (state_q)
            StStartup: begin
                if (word_done) begin
                    word_cnt_d = word_cnt_q + WcW'(1);
                    if (word_cnt_q == WcW'(STARTUP_WORDS - 1)) begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (word_done) begin
                    out_data_d  = shift_d;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = StFill;
                end
            end
            StAlarm: begin
            end
            default: state_d = StStartup;
        endcase

        // A failure overrides everything; a coincident handshake has already
        // been taken by the consumer, so only out_valid needs dropping.
        if (hc_fail) begin
            state_d     = StAlarm;
            alarm_d     = 1'b1;
            cause_d     = hc_cause;
            out_valid_d = 1'b0;
            shift_d     = '0;
            bit_cnt_d   = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StStartup;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
            cause_q     <= CauseNone;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            alarm_q     <= alarm_d;
            cause_q     <= cause_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign alarm       = alarm_q;
    assign alarm_cause = cause_q;

endmodule

// File: tb/tb_trng_health.sv
// Directed bench for trng_health, driving raw bits through test_mode.
module tb_trng_health;

    localparam logic [63:0] WORD = 64'hC3A5_0F96_5A3C_E178;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        test_mode = 1'b1;
    logic        test_bit = 1'b0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        alarm;
    logic [1:0]  alarm_cause;

    int n_checks = 0;
    int n_pass = 0;
    int mode = 0;
    int pidx = 0;

    trng_health dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .test_mode   (test_mode),
        .test_bit    (test_bit),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alarm       (alarm),
        .alarm_cause (alarm_cause)
    );

    always #5 clk = ~clk;

    // Bit number i of the stream for each stimulus pattern.
    function automatic logic pat_bit(input int m, input int i);
        logic [63:0] w;
        w = WORD;
        case (m)
            0:       return (i % 2) == 0;
            1:       return 1'b0;
            2:       return (i % 4) != 3;
            3:       return w[63 - (i % 64)];
            default: return (i < 330) ? ((i % 2) == 0) : 1'b0;
        endcase
    endfunction

    // One clock; with en=0 the driven bit is the inverse so a leak shows up.
    task automatic step(input logic e);
        en       = e;
        test_bit = e ? pat_bit(mode, pidx) : ~pat_bit(mode, pidx);
        @(posedge clk);
        #1;
        if (e) pidx++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        pidx = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_data !== 64'h0) $display("FAIL reset_data: got %h want 0", out_data);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (alarm !== 1'b0) $display("FAIL reset_alarm: got %b want 0", alarm);
        else n_pass++;
        n_checks++;
        if (alarm_cause !== 2'b00) $display("FAIL reset_cause: got %b want 00", alarm_cause);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_startup_delivery();
        int cyc;
        do_reset();
        mode = 0;
        cyc  = 0;
        while (out_valid !== 1'b1 && cyc < 400) begin
            step(1'b1);
            cyc++;
        end
        n_checks++;
        if (cyc != 321) $display("FAIL first_valid_latency: got %0d want 321", cyc);
        else n_pass++;
        n_checks++;
        if (out_data !== 64'hAAAA_AAAA_AAAA_AAAA)
            $display("FAIL first_word: got %h want aaaaaaaaaaaaaaaa", out_data);
        else n_pass++;
    endtask

    // Continues from the held 0xAAAA word of test_startup_delivery.
    task automatic test_hold_backpressure();
        int bad;
        int cyc;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1);
            if (out_valid !== 1'b1 || alarm !== 1'b0 || out_data !== 64'hAAAA_AAAA_AAAA_AAAA)
                bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
        else n_pass++;
        out_ready = 1'b1;
        step(1'b1);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL handshake_clear: got %b want 0", out_valid);
        else n_pass++;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            step(1'b1);
            cyc++;
        end
        n_checks++;
        if (cyc != 64) $display("FAIL refill_latency: got %0d want 64", cyc);
        else n_pass++;
        n_checks++;
        if (out_data !== 64'h5555_5555_5555_5555)
            $display("FAIL second_word: got %h want 5555555555555555", out_data);
        else n_pass++;
    endtask

    task automatic test_rct_alarm();
        int bad;
        do_reset();
        mode = 1;
        repeat (32) step(1'b1);
        n_checks++;
        if (alarm !== 1'b0) $display("FAIL rct_early: got %b want 0", alarm);
        else n_pass++;
        step(1'b1);
        n_checks++;
        if (alarm !== 1'b1 || alarm_cause !== 2'b01)
            $display("FAIL rct_alarm: got alarm=%b cause=%b want 1/01", alarm, alarm_cause);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'b1);
            if (out_valid !== 1'b0 || alarm !== 1'b1 || alarm_cause !== 2'b01) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL rct_sticky: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_apt_alarm();
        do_reset();
        mode = 2;
        repeat (785) step(1'b1);
        n_checks++;
        if (alarm !== 1'b0) $display("FAIL apt_early: got %b want 0", alarm);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hEEEE_EEEE_EEEE_EEEE)
            $display("FAIL apt_word: got v=%b %h want 1 eeeeeeeeeeeeeeee", out_valid, out_data);
        else n_pass++;
        step(1'b1);
        n_checks++;
        if (alarm !== 1'b1 || alarm_cause !== 2'b10)
            $display("FAIL apt_alarm: got alarm=%b cause=%b want 1/10", alarm, alarm_cause);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL apt_valid_drop: got %b want 0", out_valid);
        else n_pass++;
    endtask

    // Runs straight after the APT alarm, when out_data still holds a word.
    task automatic test_reset_recovery();
        int cyc;
        rst = 1'b1;
        step(1'b1);
        rst  = 1'b0;
        pidx = 0;
        n_checks++;
        if (out_data !== 64'h0 || out_valid !== 1'b0 || alarm !== 1'b0 || alarm_cause !== 2'b00)
            $display("FAIL recover_outputs: got d=%h v=%b a=%b c=%b want all 0",
                     out_data, out_valid, alarm, alarm_cause);
        else n_pass++;
        mode = 0;
        cyc  = 0;
        while (out_valid !== 1'b1 && cyc < 400) begin
            step(1'b1);
            cyc++;
        end
        n_checks++;
        if (cyc != 321 || out_data !== 64'hAAAA_AAAA_AAAA_AAAA)
            $display("FAIL recover_delivery: got cyc=%0d %h want 321 aaaaaaaaaaaaaaaa",
                     cyc, out_data);
        else n_pass++;
    endtask

    task automatic test_en_gap();
        int bad;
        int cyc;
        do_reset();
        mode = 3;
        repeat (280) step(1'b1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0);
            if (out_valid !== 1'b0 || alarm !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL gap_frozen: got %0d bad cycles want 0", bad);
        else n_pass++;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            step(1'b1);
            cyc++;
        end
        n_checks++;
        if (cyc != 41) $display("FAIL gap_latency: got %0d want 41", cyc);
        else n_pass++;
        n_checks++;
        if (out_data !== WORD) $display("FAIL gap_word: got %h want %h", out_data, WORD);
        else n_pass++;
    endtask

    // Dropped bits in HOLD still feed RCT; its failure lands with a handshake.
    task automatic test_alarm_with_handshake();
        do_reset();
        mode = 4;
        repeat (361) step(1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || alarm !== 1'b0)
            $display("FAIL hs_pre: got v=%b a=%b want 1/0", out_valid, alarm);
        else n_pass++;
        out_ready = 1'b1;
        step(1'b1);
        out_ready = 1'b0;
        n_checks++;
        if (alarm !== 1'b1 || alarm_cause !== 2'b01 || out_valid !== 1'b0)
            $display("FAIL hs_alarm: got a=%b c=%b v=%b want 1/01/0",
                     alarm, alarm_cause, out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_startup_delivery();
        test_hold_backpressure();
        test_rct_alarm();
        test_apt_alarm();
        test_reset_recovery();
        test_en_gap();
        test_alarm_with_handshake();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
